instr_fetch: RTL and testbench

Instruction fetch unit: the producer side of the decode interface. It generates sequential PCs, issues read requests to instruction memory, and buffers returned words in order. It presents `{pc, instr, opcode}` to the decode stage (the `Ctrl` opcode input) with a valid/ready handshake. It handles branch/jump redirects by flushing buffered words and discarding in-flight responses.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEF        default first fetch address after reset
//   INSTR_OPCODE_HI/LO  opcode field position inside an instruction word
//   INSTR_BYTES         byte stride between sequential instructions
//   fetch_state_e       RUN: normal fetch, DRAIN: stale responses pending
//   align_pc()          clears the byte-offset bits of a PC
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_3000;
  localparam int          INSTR_OPCODE_HI = 31;
  localparam int          INSTR_OPCODE_LO = 26;
  localparam logic [31:0] INSTR_BYTES     = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// In-order instruction buffer holding {pc, instr} pairs.
//   push/push_data  write one entry (ignored when full unless popping)
//   pop             remove the head entry (ignored when empty)
//   flush           empty the buffer; overrides push and pop
//   head            oldest entry, count = occupancy, empty = (count == 0)
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word reads to instruction memory,
// buffers returned words in order and presents {pcOut, instr, opcode} to decode.
//   imemReq/imemAddr/imemReady             request channel (valid/ready)
//   imemRespValid/imemRespData             in-order responses, no backpressure
//   instrValid/instrReady/instr/pcOut/opcode decode channel (valid/ready)
//   redirectValid/redirectPc               flush buffer and restart fetch
//   dbg_state                              RUN, or DRAIN while stale responses remain
// Handshakes: a transfer happens in a cycle where valid && ready are both high
// at the rising clock edge; valid does not depend on ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imemReq,
  output logic [31:0]  imemAddr,
  input  logic         imemReady,
  input  logic         imemRespValid,
  input  logic [31:0]  imemRespData,
  output logic         instrValid,
  input  logic         instrReady,
  output logic [31:0]  instr,
  output logic [31:0]  pcOut,
  output logic [5:0]   opcode,
  input  logic         redirectValid,
  input  logic [31:0]  redirectPc,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  rpc_q, rpc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  fetch_state_e state_q;

  logic [CW-1:0] cnt;
  logic [63:0]   head;
  logic          empty;
  logic          accept, keep, pop;

  // outst counts every accepted request still in flight, including the ones
  // that will be dropped, so the credit check bounds the memory pipeline too.
  assign imemReq  = rst_n && !redirectValid &&
                    (({1'b0, outst_q} + {1'b0, cnt}) < DEPTH_W);
  assign imemAddr = fpc_q;
  assign accept   = imemReq && imemReady;
  assign keep     = imemRespValid && (drop_q == '0) && !redirectValid;
  assign pop      = instrValid && instrReady && !redirectValid;

  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    outst_d = outst_q + CW'(accept) - CW'(imemRespValid);
    drop_d  = drop_q;
    if (redirectValid) begin
      fpc_d  = align_pc(redirectPc);
      rpc_d  = align_pc(redirectPc);
      // drop_q is a subset of outst_q, so discarding everything in flight
      // (less the word arriving now) already covers earlier redirects.
      drop_d = outst_q - CW'(imemRespValid);
    end else begin
      if (accept) fpc_d = fpc_q + INSTR_BYTES;
      if (keep)   rpc_d = rpc_q + INSTR_BYTES;
      if (imemRespValid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (drop_d != '0) state_q <= ST_DRAIN;
        ST_DRAIN: if (drop_d == '0) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  instr_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep),
    .push_data ({rpc_q, imemRespData}),
    .pop       (pop),
    .flush     (redirectValid),
    .head      (head),
    .count     (cnt),
    .empty     (empty)
  );

  // Outputs read zero whenever the buffer is empty, which also gives the
  // all-zero reset values without resetting the storage array.
  assign instrValid = !empty;
  assign instr      = empty ? 32'd0 : head[31:0];
  assign pcOut      = empty ? 32'd0 : head[63:32];
  assign opcode     = instr[INSTR_OPCODE_HI:INSTR_OPCODE_LO];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          TIMEOUT_CYC = 20000;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         imemReq;
  logic [31:0]  imemAddr;
  logic         imemReady;
  logic         imemRespValid;
  logic [31:0]  imemRespData;
  logic         instrValid;
  logic         instrReady;
  logic [31:0]  instr;
  logic [31:0]  pcOut;
  logic [5:0]   opcode;
  logic         redirectValid;
  logic [31:0]  redirectPc;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemReady     (imemReady),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .instr         (instr),
    .pcOut         (pcOut),
    .opcode        (opcode),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fpc;
  int          epoch;
  int          last_due;
  int          cyc;
  int          total;
  int          bad;
  bit          done;

  int rdy_pct;
  int dec_pct;
  int lat_min;
  int lat_max;

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n         = 1'b0;
    imemReady     = 1'b0;
    instrReady    = 1'b0;
    imemRespValid = 1'b0;
    imemRespData  = '0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    mem_q.delete();
    exp_q.delete();
    exp_fpc  = RST_PC;
    epoch    = 0;
    last_due = 0;
    #1;
    chk("rst_imemReq", imemReq, 1'b0);
    chk("rst_instrValid", instrValid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pcOut", pcOut, 32'd0);
    chk("rst_opcode", opcode, 6'd0);
    chk("rst_state", dbg_state, ST_RUN);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cycle(input bit redir, input logic [31:0] new_pc);
    bit          exp_req, got_resp, hs, acc, stale;
    req_t        r;
    logic [63:0] h;
    int          lat;
    @(negedge clk);
    cyc++;
    imemReady     = ($urandom_range(0, 99) < rdy_pct);
    instrReady    = ($urandom_range(0, 99) < dec_pct);
    redirectValid = redir;
    redirectPc    = new_pc;
    got_resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imemRespValid = got_resp;
    imemRespData  = got_resp ? mem_q[0].data : $urandom;
    #1;
    exp_req = !redir && ((mem_q.size() + exp_q.size()) < DEPTH);
    stale = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale = 1'b1;
    chk("imemReq", imemReq, exp_req);
    if (exp_req) chk("imemAddr", imemAddr, exp_fpc);
    chk("instrValid", instrValid, exp_q.size() != 0);
    chk("state", dbg_state, stale ? ST_DRAIN : ST_RUN);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("pcOut", pcOut, h[63:32]);
      chk("instr", instr, h[31:0]);
      chk("opcode", opcode, h[31:26]);
    end
    hs  = (exp_q.size() != 0) && instrReady;
    acc = exp_req && imemReady;
    if (got_resp) r = mem_q.pop_front();
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_fpc = {new_pc[31:2], 2'b00};
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (got_resp && r.epoch == epoch) exp_q.push_back({r.addr, r.data});
      chk("no_overflow", exp_q.size() <= DEPTH, 1'b1);
      if (acc) begin
        lat = $urandom_range(lat_min, lat_max);
        r.addr  = exp_fpc;
        r.data  = $urandom;
        r.epoch = epoch;
        r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        mem_q.push_back(r);
        exp_fpc = exp_fpc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (TIMEOUT_CYC) @(posedge clk);
    chk("timeout_expired", done, 1'b1);
    $display("test done (timeout): total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    done  = 1'b0;
    rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();

    rdy_pct = 0;
    run(5);
    chk("stall_addr", imemAddr, RST_PC);

    rdy_pct = 100;
    run(12);
    cycle(1'b1, 32'h0000_7000);
    run(8);

    dec_pct = 0;
    run(10);
    chk("full_no_req", imemReq, 1'b0);
    dec_pct = 100;
    run(8);

    reset_dut();
    lat_min = 3; lat_max = 3;
    run(4);
    cycle(1'b1, 32'h0000_4002);
    run(12);

    run(2);
    cycle(1'b1, 32'h0000_5000);
    cycle(1'b1, 32'h0000_6000);
    run(12);

    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        rdy_pct = $urandom_range(30, 100);
        dec_pct = $urandom_range(20, 100);
        lat_min = $urandom_range(1, 2);
        lat_max = lat_min + $urandom_range(0, 3);
      end
      if ($urandom_range(0, 99) < 5) cycle(1'b1, $urandom);
      else                           cycle(1'b0, 32'd0);
    end

    reset_dut();
    run(30);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $finish;
  end

endmodule
